// File: rtl/status_mon_pkg.sv
// Shared constants for the status exclusion monitor: status bit map,
// default rule tables and the monitor FSM state type.
package status_mon_pkg;

  // Bit positions inside the monitored status word.
  localparam int unsigned BIT_ZERO    = 0;
  localparam int unsigned BIT_INF     = 1;
  localparam int unsigned BIT_NAN     = 2;
  localparam int unsigned BIT_TINY    = 3;
  localparam int unsigned BIT_HUGE    = 4;
  localparam int unsigned BIT_INEXACT = 5;

  // The rule tables are stored wide so any N_RULES up to MAX_RULES can take
  // a slice. Slots beyond the six defined rules hold 8'hFF, an index that is
  // out of range for any practical status width, so those rules never fire.
  localparam int unsigned MAX_RULES = 32;

  // Rule 0 sits in the least significant byte.
  // Pairs: zero/inf, zero/nan, zero/huge, inf/tiny, nan/tiny, huge/tiny.
  localparam logic [MAX_RULES*8-1:0] DEF_RULE_A = {
    {(MAX_RULES-6){8'hFF}},
    8'(BIT_HUGE), 8'(BIT_NAN), 8'(BIT_INF),
    8'(BIT_ZERO), 8'(BIT_ZERO), 8'(BIT_ZERO)
  };
  localparam logic [MAX_RULES*8-1:0] DEF_RULE_B = {
    {(MAX_RULES-6){8'hFF}},
    8'(BIT_TINY), 8'(BIT_TINY), 8'(BIT_TINY),
    8'(BIT_HUGE), 8'(BIT_NAN), 8'(BIT_INF)
  };

  // Monitor FSM: armed until the first violating sample, then tripped
  // until an explicit clear.
  typedef enum logic {
    ST_ARMED   = 1'b0,
    ST_TRIPPED = 1'b1
  } mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear has priority; increments stop once the counter reaches all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/status_excl_monitor.sv
// Watches a status word for pairs of flags that must never be set together.
// Reports per-sample violations one cycle later, keeps sticky flags and
// saturating per-rule counters, and captures the first failing sample.
//
// Handshake: a sample is accepted on a rising edge where status_valid=1 and
// clear=0; its result appears on viol_valid/viol_vec after that edge for
// exactly one cycle. There is no back-pressure.
module status_excl_monitor
  import status_mon_pkg::*;
#(
  parameter int N_STATUS = 8,
  parameter int N_RULES  = 6,
  parameter int CNT_W    = 16,
  parameter logic [N_RULES*8-1:0] RULE_A = DEF_RULE_A[N_RULES*8-1:0],
  parameter logic [N_RULES*8-1:0] RULE_B = DEF_RULE_B[N_RULES*8-1:0],
  localparam int RW = $clog2(N_RULES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                status_valid,
  input  logic [N_STATUS-1:0] status,
  input  logic                clear,
  input  logic [RW-1:0]       rd_rule,
  output logic                viol_valid,
  output logic [N_RULES-1:0]  viol_vec,
  output logic [N_RULES-1:0]  viol_sticky,
  output logic                tripped,
  output logic [RW-1:0]       first_rule,
  output logic [N_STATUS-1:0] first_status,
  output logic [CNT_W-1:0]    first_idx,
  output logic [CNT_W-1:0]    rd_count,
  output logic                dbg_state
);

  mon_state_t          state_q, state_d;
  logic [N_RULES-1:0]  hit;
  logic                accept;
  logic                any_hit;
  logic                capture_en;
  logic [RW-1:0]       low_rule;
  logic [CNT_W-1:0]    sample_cnt;
  logic [CNT_W-1:0]    rule_cnt [N_RULES];
  logic [CNT_W-1:0]    rd_mux;

  // clear beats a simultaneous sample: the sample is simply dropped.
  assign accept  = status_valid & ~clear;
  assign any_hit = |hit;

  // Rule evaluation; out-of-range bit indices are resolved at elaboration
  // so such rules are tied off.
  for (genvar r = 0; r < N_RULES; r++) begin : g_rule
    localparam int unsigned IA = int'(RULE_A[r*8 +: 8]);
    localparam int unsigned IB = int'(RULE_B[r*8 +: 8]);
    if ((IA < N_STATUS) && (IB < N_STATUS)) begin : g_live
      assign hit[r] = status_valid & status[IA] & status[IB];
    end else begin : g_dead
      assign hit[r] = 1'b0;
    end
  end

  // Lowest-index violated rule of the current sample.
  always_comb begin
    low_rule = '0;
    for (int r = N_RULES - 1; r >= 0; r--) begin
      if (hit[r]) low_rule = RW'(r);
    end
  end

  // Next-state logic: trip on the first violating sample, re-arm on clear.
  always_comb begin
    state_d    = state_q;
    capture_en = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (accept && any_hit) begin
          state_d    = ST_TRIPPED;
          capture_en = 1'b1;
        end
      end
      ST_TRIPPED: begin
        if (clear) state_d = ST_ARMED;
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ARMED;
    else        state_q <= state_d;
  end

  assign tripped   = (state_q == ST_TRIPPED);
  assign dbg_state = state_q;

  // Per-sample result, sticky flags, sample numbering and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_valid   <= 1'b0;
      viol_vec     <= '0;
      viol_sticky  <= '0;
      sample_cnt   <= '0;
      first_rule   <= '0;
      first_status <= '0;
      first_idx    <= '0;
    end else if (clear) begin
      viol_valid   <= 1'b0;
      viol_vec     <= '0;
      viol_sticky  <= '0;
      sample_cnt   <= '0;
      first_rule   <= '0;
      first_status <= '0;
      first_idx    <= '0;
    end else begin
      viol_valid <= accept;
      viol_vec   <= accept ? hit : '0;
      if (accept) begin
        viol_sticky <= viol_sticky | hit;
        sample_cnt  <= sample_cnt + CNT_W'(1);
      end
      if (capture_en) begin
        first_rule   <= low_rule;
        first_status <= status;
        first_idx    <= sample_cnt;
      end
    end
  end

  // One saturating counter per rule.
  for (genvar r = 0; r < N_RULES; r++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (accept & hit[r]),
      .cnt   (rule_cnt[r])
    );
  end

  // Read mux; indices with no rule behind them read as zero.
  always_comb begin
    rd_mux = '0;
    for (int r = 0; r < N_RULES; r++) begin
      if (rd_rule == RW'(r)) rd_mux = rule_cnt[r];
    end
  end

  // Registered counter read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_count <= '0;
    else        rd_count <= rd_mux;
  end

endmodule

// File: tb/tb_status_excl_monitor.sv
// Bench for status_excl_monitor: directed scenarios plus random samples,
// scored against a behavioural model of the exclusion rules.
module tb_status_excl_monitor;

  localparam int NS = 8;
  localparam int NR = 6;
  localparam int CW = 4;
  localparam int RW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          status_valid;
  logic [NS-1:0] status;
  logic          clear;
  logic [RW-1:0] rd_rule;
  logic          viol_valid;
  logic [NR-1:0] viol_vec;
  logic [NR-1:0] viol_sticky;
  logic          tripped;
  logic [RW-1:0] first_rule;
  logic [NS-1:0] first_status;
  logic [CW-1:0] first_idx;
  logic [CW-1:0] rd_count;
  logic          dbg_state;

  status_excl_monitor #(
    .N_STATUS (NS),
    .N_RULES  (NR),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .status_valid (status_valid),
    .status       (status),
    .clear        (clear),
    .rd_rule      (rd_rule),
    .viol_valid   (viol_valid),
    .viol_vec     (viol_vec),
    .viol_sticky  (viol_sticky),
    .tripped      (tripped),
    .first_rule   (first_rule),
    .first_status (first_status),
    .first_idx    (first_idx),
    .rd_count     (rd_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model ----------------
  int rule_a [NR] = '{0, 0, 0, 1, 2, 3};
  int rule_b [NR] = '{1, 2, 4, 3, 3, 4};
  int max_cnt = (1 << CW) - 1;

  int            cnt_m [NR];
  int            sample_m;
  bit            trip_m;
  int            frule_m;
  int            fstat_m;
  int            fidx_m;
  logic [NR-1:0] sticky_m;

  typedef struct packed {
    logic [NR-1:0] vec;
    logic [NR-1:0] sticky;
    logic          trip;
    logic [RW-1:0] frule;
    logic [NS-1:0] fstat;
    logic [CW-1:0] fidx;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) cnt_m[r] = 0;
    sample_m = 0;
    trip_m   = 1'b0;
    frule_m  = 0;
    fstat_m  = 0;
    fidx_m   = 0;
    sticky_m = '0;
  endtask

  task automatic model_sample(input logic [NS-1:0] s);
    logic [NR-1:0] vec;
    int lowest;
    exp_t e;
    vec = '0;
    lowest = -1;
    for (int r = 0; r < NR; r++) begin
      if (s[rule_a[r]] && s[rule_b[r]]) begin
        vec[r] = 1'b1;
        if (lowest < 0) lowest = r;
        if (cnt_m[r] < max_cnt) cnt_m[r]++;
      end
    end
    if (!trip_m && lowest >= 0) begin
      trip_m  = 1'b1;
      frule_m = lowest;
      fstat_m = int'(s);
      fidx_m  = sample_m;
    end
    sticky_m = sticky_m | vec;
    sample_m = (sample_m + 1) % (1 << CW);
    e.vec    = vec;
    e.sticky = sticky_m;
    e.trip   = trip_m;
    e.frule  = RW'(frule_m);
    e.fstat  = NS'(fstat_m);
    e.fidx   = CW'(fidx_m);
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [NS-1:0] s, input logic c);
    @(posedge clk);
    #1;
    status_valid = v;
    status       = s;
    clear        = c;
    if (c)      model_clear();
    else if (v) model_sample(s);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    status_valid = 1'b0;
    clear        = 1'b0;
    chk({tag, "_tripped"},      32'(tripped),      32'(trip_m));
    chk({tag, "_dbg_state"},    32'(dbg_state),    32'(trip_m));
    chk({tag, "_sticky"},       32'(viol_sticky),  32'(sticky_m));
    chk({tag, "_first_rule"},   32'(first_rule),   32'(frule_m));
    chk({tag, "_first_status"}, 32'(first_status), 32'(fstat_m));
    chk({tag, "_first_idx"},    32'(first_idx),    32'(fidx_m));
  endtask

  task automatic check_rd(input int r);
    @(posedge clk);
    #1;
    status_valid = 1'b0;
    clear        = 1'b0;
    rd_rule      = RW'(r);
    @(posedge clk);
    #1;
    chk($sformatf("rd_count_rule%0d", r), 32'(rd_count), (r < NR) ? 32'(cnt_m[r]) : 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_viol_valid"},   32'(viol_valid),   32'd0);
    chk({tag, "_viol_vec"},     32'(viol_vec),     32'd0);
    chk({tag, "_sticky"},       32'(viol_sticky),  32'd0);
    chk({tag, "_tripped"},      32'(tripped),      32'd0);
    chk({tag, "_first_rule"},   32'(first_rule),   32'd0);
    chk({tag, "_first_status"}, 32'(first_status), 32'd0);
    chk({tag, "_first_idx"},    32'(first_idx),    32'd0);
    chk({tag, "_rd_count"},     32'(rd_count),     32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (viol_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_viol_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("viol_vec",     32'(viol_vec),     32'(e.vec));
        chk("viol_sticky",  32'(viol_sticky),  32'(e.sticky));
        chk("tripped",      32'(tripped),      32'(e.trip));
        chk("first_rule",   32'(first_rule),   32'(e.frule));
        chk("first_status", 32'(first_status), 32'(e.fstat));
        chk("first_idx",    32'(first_idx),    32'(e.fidx));
      end
    end else if (rst_n === 1'b1) begin
      chk("viol_vec_idle", 32'(viol_vec), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    status_valid = 1'b0;
    status       = '0;
    clear        = 1'b0;
    rd_rule      = '0;
    model_clear();
    #3;
    check_all_zero("reset");
    #9;
    rst_n = 1'b1;

    // Single zero+inf sample trips on rule 0 at sample 0.
    drive(1'b1, 8'h03, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    idle_check("first_trip");

    // Clear, then a violation on the third sample.
    drive(1'b0, 8'h00, 1'b1);
    idle_check("after_clear");
    drive(1'b1, 8'h20, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h0C, 1'b0);
    drive(1'b1, 8'h03, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    idle_check("capture_hold");

    // clear together with a violating sample: sample dropped.
    drive(1'b1, 8'h03, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    idle_check("clear_wins");
    check_rd(0);

    // Random samples with occasional clears.
    for (int i = 0; i < 120; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            NS'($urandom_range(0, 255)),
            ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0);
    idle_check("random");
    for (int r = 0; r < 8; r++) check_rd(r);

    // Saturation: every rule fires on 8'h1F.
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'h1F, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    idle_check("saturate");
    chk("sticky_all", 32'(viol_sticky), 32'h3F);
    for (int r = 0; r < NR; r++) check_rd(r);
    check_rd(7);

    // Asynchronous reset while tripped, away from the clock edge.
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h03, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    idle_check("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h0A, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    idle_check("post_reset");

    @(posedge clk);
    @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/status_excl_monitor.md
STATUS_EXCL_MONITOR -- requirements
Module: status_excl_monitor

Interface
REQ-001 SHALL have parameter N_STATUS, default 8, width of monitored status word.
REQ-002 SHALL have parameter N_RULES, default 6, number of mutual-exclusion rules.
REQ-003 SHALL have parameter CNT_W, default 16, width of per-rule violation counters and sample counter.
REQ-004 SHALL have parameters RULE_A and RULE_B, packed N_RULES x 8-bit bit-index tables; defaults are the pairs (0,1) (0,2) (0,4) (1,3) (2,3) (3,4): zero/inf, zero/nan, zero/huge, inf/tiny, nan/tiny, huge/tiny.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 status_valid  input  1  status word valid this cycle.
REQ-008 status  input  N_STATUS  status word; bit map zero=0, inf=1, nan=2, tiny=3, huge=4, inexact=5, bits 7:6 reserved.
REQ-009 clear  input  1  synchronous clear of counters, sticky flags and capture.
REQ-010 rd_rule  input  $clog2(N_RULES)  rule index for the counter read port.
REQ-011 viol_valid  output  1  viol_vec valid, one cycle after the sampled status.
REQ-012 viol_vec  output  N_RULES  per-rule violation of the last sample.
REQ-013 viol_sticky  output  N_RULES  OR of all violations since reset/clear.
REQ-014 tripped  output  1  high while the FSM is in TRIPPED.
REQ-015 first_rule  output  $clog2(N_RULES)  lowest-index rule violated by the first failing sample.
REQ-016 first_status  output  N_STATUS  status word of the first failing sample.
REQ-017 first_idx  output  CNT_W  sample number of the first failing sample.
REQ-018 rd_count  output  CNT_W  violation count of rule rd_rule, registered.

Function
REQ-019 Rule r SHALL be violated when status_valid=1 and status[RULE_A[r]] and status[RULE_B[r]] are both 1.
REQ-020 viol_valid and viol_vec SHALL be registered: 1-cycle latency from the sample; viol_vec SHALL be 0 whenever viol_valid=0.
REQ-021 Sample counter SHALL increment on every accepted sample, wrap at 2^CNT_W, and start at 0.
REQ-022 Each rule counter SHALL increment by 1 per violating sample and saturate at 2^CNT_W-1.
REQ-023 FSM states: ARMED (reset) and TRIPPED; ARMED->TRIPPED on the first sample with any violation; TRIPPED->ARMED only on clear.
REQ-024 On the ARMED->TRIPPED transition, first_rule/first_status/first_idx SHALL be captured in the same edge as viol_vec; further violations while TRIPPED SHALL NOT overwrite the capture.
REQ-025 first_idx SHALL equal the sample counter value before increment (first sample = 0).
REQ-026 clear and status_valid in the same cycle: clear wins and the sample is dropped (no count, no capture, viol_valid=0 next cycle).
REQ-027 rd_count SHALL reflect the counter value one cycle after rd_rule is presented; rd_rule >= N_RULES SHALL return 0.
REQ-028 Rules whose RULE_A or RULE_B index >= N_STATUS SHALL never fire.

Reset
REQ-029 rst_n low SHALL asynchronously force state ARMED and all outputs, counters and capture registers to 0.
REQ-030 Reset deassertion mid-stream SHALL make the first accepted sample after release sample number 0.

Structure
REQ-031 Package status_mon_pkg SHALL hold the status bit-index constants, the default RULE_A/RULE_B tables and the FSM state typedef.
REQ-032 One sub-module sat_counter (parametrised width, inc, clr, saturation) SHALL be instantiated N_RULES times.

Verification
REQ-033 status=8'h03 valid, one cycle -> next cycle viol_valid=1, viol_vec=6'b000001, tripped=1, first_rule=0, first_status=8'h03, first_idx=0.
REQ-034 Samples 8'h20, 8'h01, 8'h0C -> third sample flags viol_vec=6'b010000 with first_rule=4, first_idx=2; later 8'h03 leaves the capture unchanged.
REQ-035 CNT_W=4, 20 samples of 8'h1F -> rd_count for rules 0..5 all 15 (saturated); viol_sticky=6'h3F.
REQ-036 clear asserted together with valid status=8'h03 -> no counter change, viol_valid=0, tripped=0, capture zero.
REQ-037 rst_n pulsed low asynchronously mid-stream while TRIPPED -> all outputs 0 immediately; next sample 8'h0A -> first_idx=0, first_rule=3.
REQ-038 rd_rule=7 with N_RULES=6 -> rd_count=0.
